// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with Shift/Caps tracking and a FWFT output FIFO.
// Optional TYPEMATIC_FILTER_EN suppresses auto-repeated make codes.
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       overflow
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    localparam logic [7:0]     CODE_BRK   = 8'hF0;
    localparam logic [7:0]     CODE_EXT   = 8'hE0;
    localparam logic [7:0]     CODE_LSHFT = 8'h12;
    localparam logic [7:0]     CODE_RSHFT = 8'h59;
    localparam logic [7:0]     CODE_CAPS  = 8'h58;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    // Returns {mapped, is_letter, lower-case character}.
    function automatic logic [9:0] lookup(input logic [7:0] code);
        case (code)
            8'h1C: lookup = {2'b11, 8'h61}; 8'h32: lookup = {2'b11, 8'h62};
            8'h21: lookup = {2'b11, 8'h63}; 8'h23: lookup = {2'b11, 8'h64};
            8'h24: lookup = {2'b11, 8'h65}; 8'h2B: lookup = {2'b11, 8'h66};
            8'h34: lookup = {2'b11, 8'h67}; 8'h33: lookup = {2'b11, 8'h68};
            8'h43: lookup = {2'b11, 8'h69}; 8'h3B: lookup = {2'b11, 8'h6A};
            8'h42: lookup = {2'b11, 8'h6B}; 8'h4B: lookup = {2'b11, 8'h6C};
            8'h3A: lookup = {2'b11, 8'h6D}; 8'h31: lookup = {2'b11, 8'h6E};
            8'h44: lookup = {2'b11, 8'h6F}; 8'h4D: lookup = {2'b11, 8'h70};
            8'h15: lookup = {2'b11, 8'h71}; 8'h2D: lookup = {2'b11, 8'h72};
            8'h1B: lookup = {2'b11, 8'h73}; 8'h2C: lookup = {2'b11, 8'h74};
            8'h3C: lookup = {2'b11, 8'h75}; 8'h2A: lookup = {2'b11, 8'h76};
            8'h1D: lookup = {2'b11, 8'h77}; 8'h22: lookup = {2'b11, 8'h78};
            8'h35: lookup = {2'b11, 8'h79}; 8'h1A: lookup = {2'b11, 8'h7A};
            8'h45: lookup = {2'b10, 8'h30}; 8'h16: lookup = {2'b10, 8'h31};
            8'h1E: lookup = {2'b10, 8'h32}; 8'h26: lookup = {2'b10, 8'h33};
            8'h25: lookup = {2'b10, 8'h34}; 8'h2E: lookup = {2'b10, 8'h35};
            8'h36: lookup = {2'b10, 8'h36}; 8'h3D: lookup = {2'b10, 8'h37};
            8'h3E: lookup = {2'b10, 8'h38}; 8'h46: lookup = {2'b10, 8'h39};
            8'h29: lookup = {2'b10, 8'h20}; 8'h5A: lookup = {2'b10, 8'h0D};
            8'h66: lookup = {2'b10, 8'h08};
            default: lookup = 10'h000;
        endcase
    endfunction

    state_t           state;
    logic             shift_l, shift_r, caps_held;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [9:0]       map;
    logic [7:0]       char_in;
    logic             repeat_hit, push_req, push, pop, full;
`ifdef TYPEMATIC_FILTER_EN
    logic [7:0]       last_make;
`endif

    assign shift_active = shift_l | shift_r;
    assign ascii_valid  = (count != '0);
    assign ascii_out    = ascii_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        map        = lookup(scan_code);
        char_in    = (map[8] && (shift_active ^ caps_lock)) ? map[7:0] - 8'h20 : map[7:0];
`ifdef TYPEMATIC_FILTER_EN
        repeat_hit = (scan_code == last_make);
`else
        repeat_hit = 1'b0;
`endif
        push_req   = scan_valid && (state == IDLE) && map[9] && !repeat_hit;
        pop        = ascii_ready && ascii_valid;
        full       = (count == FULL_COUNT);
        push       = push_req && (!full || pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_lock <= 1'b0;
            caps_held <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            last_make <= 8'h00;
`endif
        end else if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == CODE_BRK)      state <= BRK;
                    else if (scan_code == CODE_EXT) state <= EXT;
                    else begin
`ifdef TYPEMATIC_FILTER_EN
                        last_make <= scan_code;
`endif
                        if (scan_code == CODE_LSHFT) shift_l <= 1'b1;
                        if (scan_code == CODE_RSHFT) shift_r <= 1'b1;
                        if (scan_code == CODE_CAPS) begin
                            caps_held <= 1'b1;
                            if (!caps_held) caps_lock <= !caps_lock;
                        end
                    end
                end
                BRK: begin
                    if (scan_code == CODE_LSHFT) shift_l   <= 1'b0;
                    if (scan_code == CODE_RSHFT) shift_r   <= 1'b0;
                    if (scan_code == CODE_CAPS)  caps_held <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
                    if (scan_code == last_make)  last_make <= 8'h00;
`endif
                    state <= IDLE;
                end
                EXT:     state <= (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W)'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the count gates ascii_out, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= char_in;
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Randomized self-checking bench for ps2_ascii_decoder against a keyboard-level reference model.
module tb_ps2_ascii_decoder;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .ascii_out(ascii_out), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .shift_active(shift_active), .caps_lock(caps_lock), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Keyboard-level reference model
    logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_code [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [16]        = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h29, 8'h5A, 8'h66,
                                     8'h75, 8'h05, 8'h76, 8'hF0, 8'h12, 8'h58, 8'h1C, 8'h45};

    logic [7:0] exp_q [$];
    bit         m_sl, m_sr, m_caps, m_held, m_f0, m_e0, m_ovf;
    logic [7:0] m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_sl, m_sr, m_caps, m_held, m_f0, m_e0, m_ovf} = '0;
        m_last = 8'h00;
        exp_q.delete();
    endtask

    // Produces the character a byte should yield, if any, and updates the keyboard state.
    task automatic model_step(input logic [7:0] b, output bit has, output logic [7:0] ch);
        bit rep;
        has = 1'b0;
        ch  = 8'h00;
        rep = 1'b0;
        if (m_e0) begin
            if (!m_f0 && b == 8'hF0) m_f0 = 1'b1;
            else begin m_e0 = 1'b0; m_f0 = 1'b0; end
        end else if (m_f0) begin
            if (b == 8'h12) m_sl = 1'b0;
            if (b == 8'h59) m_sr = 1'b0;
            if (b == 8'h58) m_held = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
            if (b == m_last) m_last = 8'h00;
`endif
            m_f0 = 1'b0;
        end else if (b == 8'hF0) m_f0 = 1'b1;
        else if (b == 8'hE0) m_e0 = 1'b1;
        else begin
`ifdef TYPEMATIC_FILTER_EN
            rep    = (b == m_last);
            m_last = b;
`endif
            if (b == 8'h12) m_sl = 1'b1;
            else if (b == 8'h59) m_sr = 1'b1;
            else if (b == 8'h58) begin
                if (!m_held) m_caps = !m_caps;
                m_held = 1'b1;
            end else if (!rep) begin
                for (int i = 0; i < 26; i++)
                    if (b == letter_code[i]) begin
                        has = 1'b1;
                        ch  = ((m_sl | m_sr) ^ m_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
                    end
                for (int i = 0; i < 10; i++)
                    if (b == digit_code[i]) begin has = 1'b1; ch = 8'(8'h30 + i); end
                if (b == 8'h29) begin has = 1'b1; ch = 8'h20; end
                if (b == 8'h5A) begin has = 1'b1; ch = 8'h0D; end
                if (b == 8'h66) begin has = 1'b1; ch = 8'h08; end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_shift"}, shift_active, m_sl | m_sr);
        check({tag, "_caps"}, caps_lock, m_caps);
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_valid"}, ascii_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check({tag, "_head"}, ascii_out, exp_q[0]);
        else                   check({tag, "_idle_out"}, ascii_out, 8'h00);
    endtask

    // One strobe, optionally with the consumer popping in the same cycle.
    task automatic send(input logic [7:0] b, input bit pop);
        bit         has;
        logic [7:0] ch;
        @(negedge clock);
        scan_code   = b;
        scan_valid  = 1'b1;
        ascii_ready = pop;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        model_step(b, has, ch);
        if (has) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ch);
            else m_ovf = 1'b1;
        end
        @(negedge clock);
        scan_valid  = 1'b0;
        ascii_ready = 1'b0;
        check_outputs("send");
    endtask

    task automatic drain();
        while (exp_q.size() != 0) begin
            check("drain_valid", ascii_valid, 1);
            check("drain_data", ascii_out, exp_q.pop_front());
            ascii_ready = 1'b1;
            @(negedge clock);
            ascii_ready = 1'b0;
        end
        check("drain_empty", ascii_valid, 0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #10;
        @(negedge clock);
        reset = 1'b0;
        check_outputs("reset");
    endtask

    task automatic send_seq(input logic [7:0] seq [$]);
        foreach (seq[i]) send(seq[i], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        scan_code   = 8'h00;
        scan_valid  = 1'b0;
        ascii_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_outputs("por");

        send(8'h1C, 1'b0);
        drain();
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
        drain();
        send_seq('{8'h58, 8'hF0, 8'h58, 8'h32, 8'h16, 8'h12, 8'h32});
        drain();
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C, 8'h21});
        drain();

        // Overflow, then simultaneous push/pop while full
        send_seq('{8'hF0, 8'h12, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
        send(8'h35, 1'b1);
        send(8'h3C, 1'b1);
        drain();

        // Reset landing between a break prefix and its key
        send(8'hF0, 1'b0);
        do_reset();
        send(8'h1C, 1'b0);
        drain();
        send_seq('{8'h1C, 8'h1C, 8'h1C});
        drain();

        for (int burst = 0; burst < 60; burst++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                case ($urandom_range(0, 3))
                    0, 1:    b = letter_code[$urandom_range(0, 25)];
                    2:       b = pool[$urandom_range(0, 15)];
                    default: b = digit_code[$urandom_range(0, 9)];
                endcase
                send(b, 1'($urandom_range(0, 2) == 0));
            end
            if ($urandom_range(0, 9) == 0) do_reset();
            else if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
